// File: rtl/bbox_raster_sequencer.sv
// Triangle bounding-box controller: latches three Q10.6 vertices, forms a rounded,
// screen-clamped integer box, then streams every pixel of the box in raster order.
module bbox_raster_sequencer #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int FRAC_BITS = 6
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [15:0] v0x,
  input  logic [15:0] v1x,
  input  logic [15:0] v2x,
  input  logic [15:0] v0y,
  input  logic [15:0] v1y,
  input  logic [15:0] v2y,
  input  logic        abort,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_last,
  output logic        busy,
  output logic        done,
  output logic [9:0]  XMIN,
  output logic [9:0]  XMAX,
  output logic [9:0]  YMIN,
  output logic [9:0]  YMAX,
  output logic [1:0]  dbg_state
);

  // Both handshakes: a transfer happens on a rising CLK edge where valid && ready;
  // once raised, pix_valid and its payload hold until that transfer (or abort).

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BOX  = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [10:0] W_LIM    = 11'(SCREEN_W - 1);
  localparam logic [10:0] H_LIM    = 11'(SCREEN_H - 1);
  localparam logic [16:0] HALF_LSB = 17'(1 << (FRAC_BITS - 1));

  state_t      state_q, state_d;
  logic [15:0] vx0_q, vx1_q, vx2_q, vy0_q, vy1_q, vy2_q;
  logic [15:0] vx0_d, vx1_d, vx2_d, vy0_d, vy1_d, vy2_d;
  logic [9:0]  xmin_q, xmax_q, ymin_q, ymax_q;
  logic [9:0]  xmin_d, xmax_d, ymin_d, ymax_d;
  logic [9:0]  cur_x_q, cur_y_q, cur_x_d, cur_y_d;
  logic [10:0] rx_min, rx_max, ry_min, ry_max;
  logic [9:0]  xmin_c, xmax_c, ymin_c, ymax_c;
  logic        box_empty;

  function automatic logic [15:0] min3(input logic [15:0] a, b, c);
    logic [15:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [15:0] max3(input logic [15:0] a, b, c);
    logic [15:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Round to nearest: the 17-bit sum keeps the carry out of 0xFFFF + half.
  function automatic logic [10:0] round_px(input logic [15:0] v);
    logic [16:0] s;
    s = {1'b0, v} + HALF_LSB;
    return 11'(s >> FRAC_BITS);
  endfunction

  always_comb begin
    rx_min = round_px(min3(vx0_q, vx1_q, vx2_q));
    rx_max = round_px(max3(vx0_q, vx1_q, vx2_q));
    ry_min = round_px(min3(vy0_q, vy1_q, vy2_q));
    ry_max = round_px(max3(vy0_q, vy1_q, vy2_q));
    // A min beyond 1023 only occurs for an empty box; saturate so it fits the register.
    xmin_c = rx_min[10] ? 10'h3FF : rx_min[9:0];
    ymin_c = ry_min[10] ? 10'h3FF : ry_min[9:0];
    xmax_c = (rx_max > W_LIM) ? W_LIM[9:0] : rx_max[9:0];
    ymax_c = (ry_max > H_LIM) ? H_LIM[9:0] : ry_max[9:0];
    box_empty = (rx_min > W_LIM) || (ry_min > H_LIM);
  end

  assign tri_ready = (state_q == S_IDLE);
  assign pix_valid = (state_q == S_SCAN);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pix_x     = cur_x_q;
  assign pix_y     = cur_y_q;
  assign pix_last  = pix_valid && (cur_x_q == xmax_q) && (cur_y_q == ymax_q);
  assign XMIN      = xmin_q;
  assign XMAX      = xmax_q;
  assign YMIN      = ymin_q;
  assign YMAX      = ymax_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    vx0_d = vx0_q; vx1_d = vx1_q; vx2_d = vx2_q;
    vy0_d = vy0_q; vy1_d = vy1_q; vy2_d = vy2_q;
    xmin_d = xmin_q; xmax_d = xmax_q; ymin_d = ymin_q; ymax_d = ymax_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    case (state_q)
      S_IDLE: begin
        if (tri_valid) begin
          vx0_d = v0x; vx1_d = v1x; vx2_d = v2x;
          vy0_d = v0y; vy1_d = v1y; vy2_d = v2y;
          state_d = S_BOX;
        end
      end
      S_BOX: begin
        xmin_d = xmin_c; xmax_d = xmax_c; ymin_d = ymin_c; ymax_d = ymax_c;
        cur_x_d = xmin_c;
        cur_y_d = ymin_c;
        if (abort)          state_d = S_IDLE;
        else if (box_empty) state_d = S_DONE;
        else                state_d = S_SCAN;
      end
      S_SCAN: begin
        // abort outranks a same-cycle pixel transfer.
        if (abort) begin
          state_d = S_IDLE;
        end else if (pix_ready) begin
          if (pix_last) begin
            state_d = S_DONE;
          end else if (cur_x_q < xmax_q) begin
            cur_x_d = cur_x_q + 10'd1;
          end else begin
            cur_x_d = xmin_q;
            cur_y_d = cur_y_q + 10'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      vx0_q <= '0; vx1_q <= '0; vx2_q <= '0;
      vy0_q <= '0; vy1_q <= '0; vy2_q <= '0;
      xmin_q <= '0; xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
    end else begin
      state_q <= state_d;
      vx0_q <= vx0_d; vx1_q <= vx1_d; vx2_q <= vx2_d;
      vy0_q <= vy0_d; vy1_q <= vy1_d; vy2_q <= vy2_d;
      xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
    end
  end

endmodule
